// File: rtl/mdu_hilo_seq_if.sv
// Handshake and result bus between the EX stage and the multiply/divide unit.
// The EX stage is the master: it issues operations and reads HI/LO back.
interface mdu_hilo_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_hilo_seq.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Multiply is shift-add on magnitudes, divide is restoring division on
// magnitudes; signs are re-applied (and MADD/MSUB accumulate) in FINISH.
module mdu_hilo_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  mdu_hilo_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MSUB  = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two's-complement negate of a single-width value when en is set.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic en);
    return en ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // Two's-complement negate of a double-width value when en is set.
  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic en);
    return en ? ({(2*WIDTH){1'b0}} - v) : v;
  endfunction

  // Control state
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Operation context and working registers (no reset: meaningless outside RUN/FINISH)
  logic [2:0]       op_q;
  logic             sa_q;
  logic             sb_q;
  logic             div0_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;

  // Issue-side decode
  logic                    is_mt_in;
  logic                    is_div_in;
  logic                    is_signed_in;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    a_neg_in;
  logic                    b_neg_in;
  logic                    accept_long;

  // Iteration results
  logic             is_div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  // Commit results
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  assign a_s          = bus.a;
  assign b_s          = bus.b;
  assign is_mt_in     = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
  assign is_div_in    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign is_signed_in = (bus.op == OP_MULT) || (bus.op == OP_MADD) ||
                        (bus.op == OP_MSUB) || (bus.op == OP_DIV);
  assign a_neg_in     = is_signed_in && (a_s < 0);
  assign b_neg_in     = is_signed_in && (b_s < 0);
  assign accept_long  = (state == IDLE) && bus.start && !bus.flush && !is_mt_in;
  assign is_div_q     = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // One shift-add or restoring-divide step on the working registers
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    iter_hi   = work_hi;
    iter_lo   = work_lo;
    if (is_div_q) begin
      // A clear top bit means the trial subtraction did not borrow.
      if (!div_diff[WIDTH]) begin
        iter_hi = div_diff[WIDTH-1:0];
        iter_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = div_shift[WIDTH-1:0];
        iter_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up and accumulate for the FINISH commit
  always_comb begin
    prod_s  = cond_neg2({work_hi, work_lo}, sa_q ^ sb_q);
    acc     = {hi_q, lo_q};
    mul_res = acc;
    fin_hi  = hi_q;
    fin_lo  = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: mul_res = prod_s;
      OP_MADD:           mul_res = acc + prod_s;
      OP_MSUB:           mul_res = acc - prod_s;
      default:           mul_res = acc;
    endcase
    if (is_div_q) begin
      // Remainder follows the dividend sign, which also reproduces A on divide by zero.
      fin_hi = cond_neg(work_hi, sa_q);
      fin_lo = div0_q ? {WIDTH{1'b1}} : cond_neg(work_lo, sa_q ^ sb_q);
    end else begin
      fin_hi = mul_res[2*WIDTH-1:WIDTH];
      fin_lo = mul_res[WIDTH-1:0];
    end
  end

  // Latch operand magnitudes on accept, then iterate while in RUN
  always_ff @(posedge clk) begin
    if (accept_long) begin
      op_q    <= bus.op;
      sa_q    <= a_neg_in;
      sb_q    <= b_neg_in;
      div0_q  <= (bus.b == {WIDTH{1'b0}});
      work_hi <= {WIDTH{1'b0}};
      if (is_div_in) begin
        work_lo <= cond_neg(bus.a, a_neg_in);
        opnd_q  <= cond_neg(bus.b, b_neg_in);
      end else begin
        work_lo <= cond_neg(bus.b, b_neg_in);
        opnd_q  <= cond_neg(bus.a, a_neg_in);
      end
    end else if (state == RUN) begin
      work_hi <= iter_hi;
      work_lo <= iter_lo;
    end
  end

  // Control FSM: issue, iteration count, abort, commit and the Done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (bus.op == OP_MTHI) begin
              hi_q   <= bus.a;
              done_q <= 1'b1;
            end else if (bus.op == OP_MTLO) begin
              lo_q   <= bus.a;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
              cnt    <= '0;
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= FINISH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        FINISH: begin
          // Abort wins over commit.
          if (!bus.flush) begin
            hi_q   <= fin_hi;
            lo_q   <= fin_lo;
            done_q <= 1'b1;
          end
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo_seq.sv
// Directed-vector bench for mdu_hilo_seq at WIDTH=32.
module tb_mdu_hilo_seq;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  mdu_hilo_seq_if #(.WIDTH(WIDTH)) bus ();

  mdu_hilo_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Issue one op at a negedge, then watch a fixed window counting Busy and Done.
  task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < WIDTH + 6; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      @(negedge clk);
    end
  endtask

  int bn, dn;

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    rst = 1'b0;

    // MULT -1 * 2
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, bn, dn);
    check("mult_busy_cycles", bn, 33);
    check("mult_done_pulses", dn, 1);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFE);

    // MULTU 0xFFFFFFFF * 2
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, bn, dn);
    check("multu_done_pulses", dn, 1);
    check("multu_hi", bus.hi, 32'h0000_0001);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);

    // MTHI 0, MTLO 10
    run_op(3'd6, 32'h0, 32'h0, bn, dn);
    check("mthi_busy_cycles", bn, 0);
    check("mthi_done_pulses", dn, 1);
    check("mthi_hi", bus.hi, 32'h0);
    run_op(3'd7, 32'd10, 32'h0, bn, dn);
    check("mtlo_lo", bus.lo, 32'd10);
    check("mtlo_hi_kept", bus.hi, 32'h0);

    // MADD 3 * -4 onto 10 -> -2; MSUB back to 10
    run_op(3'd2, 32'd3, 32'hFFFF_FFFC, bn, dn);
    check("madd_hi", bus.hi, 32'hFFFF_FFFF);
    check("madd_lo", bus.lo, 32'hFFFF_FFFE);
    run_op(3'd3, 32'd3, 32'hFFFF_FFFC, bn, dn);
    check("msub_hi", bus.hi, 32'h0);
    check("msub_lo", bus.lo, 32'd10);

    // Divides
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, bn, dn);
    check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd7, 32'd2, bn, dn);
    check("divu_lo", bus.lo, 32'd3);
    check("divu_hi", bus.hi, 32'd1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, bn, dn);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0);
    run_op(3'd5, 32'h0000_1234, 32'h0, bn, dn);
    check("divu0_busy_cycles", bn, 33);
    check("divu0_done_pulses", dn, 1);
    check("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    check("divu0_hi", bus.hi, 32'h0000_1234);

    // Flush in RUN, with an MTHI start pulsed while busy (must be ignored)
    dn = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (bus.done) dn++;
      bus.start = (i == 3);
      bus.op    = (i == 3) ? 3'd6 : 3'd0;
      bus.a     = (i == 3) ? 32'hDEAD_BEEF : 32'd5;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("run_still_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_run_busy", bus.busy, 0);
    for (int i = 0; i < WIDTH + 4; i++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    check("flush_run_no_done", dn, 0);
    check("flush_run_hi", bus.hi, 32'h0000_1234);
    check("flush_run_lo", bus.lo, 32'hFFFF_FFFF);

    // Flush in the FINISH cycle
    dn = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    check("finish_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_fin_busy", bus.busy, 0);
    for (int i = 0; i < 4; i++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    check("flush_fin_no_done", dn, 0);
    check("flush_fin_hi", bus.hi, 32'h0000_1234);
    check("flush_fin_lo", bus.lo, 32'hFFFF_FFFF);

    // Flush together with Start while idle: MTLO ignored
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd7; bus.a = 32'h5555_AAAA;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_lo", bus.lo, 32'hFFFF_FFFF);
    check("flush_start_done", bus.done, 0);

    // Asynchronous reset mid-DIV
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    @(negedge clk);
    rst = 1'b0;

    // MULT 6*7 after reset
    run_op(3'd0, 32'd6, 32'd7, bn, dn);
    check("post_rst_mult_done", dn, 1);
    check("post_rst_mult_lo", bus.lo, 32'd42);
    check("post_rst_mult_hi", bus.hi, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
